// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream carrying a last-word marker.
// The master drives data/valid/last and the slave drives ready.
interface bram_stream_reader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Block-RAM read master: walks an address range and streams the words out through a 4-entry credit FIFO.
// Optional sticky command-error flag when BRAM_STREAM_READER_ERR_EN is defined.
module bram_stream_reader #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_add,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [WIDTH-1:0]  rd_data,
`ifdef BRAM_STREAM_READER_ERR_EN
    output logic              err,
`endif
    bram_stream_reader_if.master m
);
    localparam int            DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic              last_p0;
    logic              vld_p1;
    logic              last_p1;
    logic [WIDTH-1:0]  fifo_data [4];
    logic [3:0]        fifo_last;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_count;
    logic [2:0]        credit_used;
    logic              hs;
    logic              cmd_ok;
    logic              issue;

    assign m.valid = (fifo_count != 3'd0);
    assign m.data  = m.valid ? fifo_data[rd_ptr] : '0;
    assign m.last  = m.valid && fifo_last[rd_ptr];
    assign hs      = m.valid && m.ready;
    assign cmd_ok  = (count != '0) && (count <= MAX_COUNT);

    // Occupancy as it will stand after this edge: a handshake frees its slot in time for the next issue.
    assign credit_used = fifo_count + 3'(vld_p1) + 3'(rd_en) - 3'(hs);
    assign issue       = (state == RUN) && (credit_used < 3'd4);

    // p0: read issue to the RAM; p1: RAM data returning, written into the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_add     <= '0;
            remaining  <= '0;
            last_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            fifo_last  <= 4'd0;
        end else begin
            done    <= 1'b0;
            rd_en   <= 1'b0;
            last_p0 <= 1'b0;
            vld_p1  <= rd_en;
            last_p1 <= last_p0;
            case (state)
                IDLE: begin
                    if (start && cmd_ok) begin
                        state     <= (count == ONE) ? DRAIN : RUN;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_add    <= base_add;
                        remaining <= count - ONE;
                        last_p0   <= (count == ONE);
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_en     <= 1'b1;
                        rd_add    <= rd_add + ADDR_W'(1);
                        remaining <= remaining - ONE;
                        last_p0   <= (remaining == ONE);
                        if (remaining == ONE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && m.last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (vld_p1) begin
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (hs) rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + 3'(vld_p1) - 3'(hs);
        end
    end

    // Payload storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (vld_p1) fifo_data[wr_ptr] <= rd_data;
    end

`ifdef BRAM_STREAM_READER_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (start) begin
            if (state != IDLE || !cmd_ok) err <= 1'b1;
            else                          err <= 1'b0;
        end
    end
`endif

endmodule
